// File: rtl/sram_arbiter_if.sv
// Bundle of signals between the two command masters, the arbiter and the SRAM pins.
// The slave modport is the arbiter's view. The master modport is the view of the masters and the SRAM.
interface sram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0_valid, req0_we, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;

    logic          req1_valid, req1_we, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic          sram_cs, sram_we, sram_rd;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  sram_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output sram_cs, sram_we, sram_rd, sram_addr, sram_wdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output sram_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  sram_cs, sram_we, sram_rd, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter for two masters sharing one single-port synchronous SRAM.
// It runs one access at a time: a write takes IDLE then ISSUE, and a read takes IDLE then ISSUE then CAPTURE.
module sram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic         clk,
    input  logic         rst,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t                state, state_nxt;
    logic [1:0]            vld, op_we, gnt;
    logic [1:0][AW-1:0]    op_addr;
    logic [1:0][DW-1:0]    op_wdata;
    logic                  sel, rr, owner;

    logic                  cs_q, we_q, rd_q;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         wdata_q;
    logic [1:0]            rsp_valid;
    logic [1:0][DW-1:0]    rsp_rdata;

    assign vld      = {bus.req1_valid, bus.req0_valid};
    assign op_we    = {bus.req1_we,    bus.req0_we};
    assign op_addr  = {bus.req1_addr,  bus.req0_addr};
    assign op_wdata = {bus.req1_wdata, bus.req0_wdata};

    // rr names the master that wins the next tie.
    always_comb begin
        gnt = vld;
        if (vld == 2'b11)
            gnt = rr ? 2'b10 : 2'b01;
    end
    assign sel = gnt[1];

    assign bus.req0_ready = (state == IDLE) & gnt[0];
    assign bus.req1_ready = (state == IDLE) & gnt[1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = we_q ? IDLE : CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            owner     <= 1'b0;
            rr        <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: if (|vld) begin
                    cs_q    <= 1'b1;
                    we_q    <= op_we[sel];
                    rd_q    <= ~op_we[sel];
                    addr_q  <= op_addr[sel];
                    wdata_q <= op_wdata[sel];
                    owner   <= sel;
                    rr      <= ~sel;
                end
                ISSUE: begin
                    cs_q <= 1'b0;
                    we_q <= 1'b0;
                    rd_q <= 1'b0;
                    if (we_q) rsp_valid[owner] <= 1'b1;
                end
                // The SRAM registered its read data at the edge that ended ISSUE.
                CAPTURE: begin
                    rsp_rdata[owner] <= bus.sram_rdata;
                    rsp_valid[owner] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sram_cs    = cs_q;
    assign bus.sram_we    = we_q;
    assign bus.sram_rd    = rd_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_rdata = rsp_rdata[0];
    assign bus.rsp1_rdata = rsp_rdata[1];
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter. Expected responses are queued when a command is accepted.
// They are compared when a response pulse appears, and a behavioural SRAM sits on the pins.
module tb_sram_arbiter;
    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } cmd_t;
    typedef struct { logic m; logic we; logic [7:0] rdata; } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.AW(8), .DW(8)) bus ();
    sram_arbiter #(.AW(8), .DW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] mem [256];
    logic [7:0] shadow [256];
    logic [7:0] srdata;
    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
        if (bus.sram_cs && bus.sram_rd) srdata <= mem[bus.sram_addr];
    end
    assign bus.sram_rdata = srdata;

    cmd_t cmd_q0[$], cmd_q1[$];
    exp_t sb[$];
    int   gnt_log[$];
    int   nchk = 0, nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rsp_seen(input int m, input logic [7:0] rdata);
        exp_t e;
        if (sb.size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", m), 1, 0);
        end else begin
            e = sb.pop_front();
            chk("rsp_master", m, e.m);
            if (!e.we) chk($sformatf("rsp%0d_rdata", m), rdata, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rsp0_valid && bus.rsp1_valid) chk("rsp_onehot", 1, 0);
            if (bus.rsp0_valid) rsp_seen(0, bus.rsp0_rdata);
            if (bus.rsp1_valid) rsp_seen(1, bus.rsp1_rdata);
        end
    end

    task automatic set_req(input int m, input logic v, input cmd_t c);
        if (m == 0) begin
            bus.req0_valid = v; bus.req0_we = c.we; bus.req0_addr = c.addr; bus.req0_wdata = c.data;
        end else begin
            bus.req1_valid = v; bus.req1_we = c.we; bus.req1_addr = c.addr; bus.req1_wdata = c.data;
        end
    endtask

    // Call this just after a rising edge. It returns #1 after the edge that follows the last accept.
    task automatic drive(input int m);
        cmd_t c;
        exp_t e;
        int   budget;
        logic acc;
        while ((m == 0) ? cmd_q0.size() != 0 : cmd_q1.size() != 0) begin
            c = (m == 0) ? cmd_q0.pop_front() : cmd_q1.pop_front();
            set_req(m, 1'b1, c);
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 100) begin
                @(negedge clk);
                if ((m == 0) ? bus.req0_ready : bus.req1_ready) acc = 1'b1;
                else budget++;
            end
            if (!acc) begin
                chk($sformatf("accept_timeout_m%0d", m), 0, 1);
                break;
            end
            e.m = m[0];
            e.we = c.we;
            e.rdata = shadow[c.addr];
            if (c.we) shadow[c.addr] = c.data;
            sb.push_back(e);
            gnt_log.push_back(m);
            @(posedge clk); #1;
        end
        c = '{we: 1'b0, addr: 8'h00, data: 8'h00};
        set_req(m, 1'b0, c);
    endtask

    task automatic push(input int m, input logic we, input logic [7:0] a, input logic [7:0] d);
        cmd_t c;
        c = '{we: we, addr: a, data: d};
        if (m == 0) cmd_q0.push_back(c);
        else        cmd_q1.push_back(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t idle_c;
        idle_c = '{we: 1'b0, addr: 8'h00, data: 8'h00};
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        srdata = 8'h00;
        set_req(0, 1'b0, idle_c);
        set_req(1, 1'b0, idle_c);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", bus.sram_cs, 0);
        chk("rst_we_rd", {bus.sram_we, bus.sram_rd}, 0);
        chk("rst_addr_wdata", {bus.sram_addr, bus.sram_wdata}, 0);
        chk("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata}, 0);
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_cs", bus.sram_cs, 0);
        end
        @(posedge clk); #1;

        // Master 0 writes 0x06 to address 0x03 and we check the SRAM pins cycle by cycle.
        push(0, 1'b1, 8'h03, 8'h06);
        drive(0);
        @(negedge clk);
        chk("wr_c1_strobes", {bus.sram_cs, bus.sram_we, bus.sram_rd}, 3'b110);
        chk("wr_c1_addr", bus.sram_addr, 8'h03);
        chk("wr_c1_wdata", bus.sram_wdata, 8'h06);
        @(negedge clk);
        chk("wr_c2_rsp0", bus.rsp0_valid, 1);
        chk("wr_c2_cs", bus.sram_cs, 0);
        wait_idle();

        // Master 0 reads address 0x03 back.
        push(0, 1'b0, 8'h03, 8'h00);
        drive(0);
        @(negedge clk);
        chk("rd_c1_strobes", {bus.sram_cs, bus.sram_we, bus.sram_rd}, 3'b101);
        @(negedge clk);
        chk("rd_c2_quiet", {bus.sram_cs, bus.rsp0_valid}, 0);
        @(negedge clk);
        chk("rd_c3_rsp0", bus.rsp0_valid, 1);
        chk("rd_c3_rdata", bus.rsp0_rdata, 8'h06);
        chk("rd_c3_rsp1", bus.rsp1_valid, 0);
        wait_idle();

        // Master 1 reads the same location, which also hands the next tie to master 0.
        push(1, 1'b0, 8'h03, 8'h00);
        drive(1);
        wait_idle();

        // Both masters hold valid continuously, so grants must alternate between them.
        gnt_log.delete();
        push(0, 1'b1, 8'h00, 8'h10); push(1, 1'b1, 8'h01, 8'h11);
        push(0, 1'b1, 8'h02, 8'h12); push(1, 1'b1, 8'h03, 8'h13);
        fork drive(0); drive(1); join
        wait_idle();
        chk("rr_wr_count", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size(); i++) chk($sformatf("rr_wr_gnt%0d", i), gnt_log[i], i % 2);

        gnt_log.delete();
        push(0, 1'b0, 8'h00, 8'h00); push(1, 1'b0, 8'h01, 8'h00);
        push(0, 1'b0, 8'h02, 8'h00); push(1, 1'b0, 8'h03, 8'h00);
        fork drive(0); drive(1); join
        wait_idle();
        chk("rr_rd_count", gnt_log.size(), 4);
        for (int i = 0; i < gnt_log.size(); i++) chk($sformatf("rr_rd_gnt%0d", i), gnt_log[i], i % 2);

        // Master 1 reads address 0x04 in the IDLE that directly follows master 0 writing 0x12 there.
        gnt_log.delete();
        push(0, 1'b1, 8'h04, 8'h12);
        push(1, 1'b0, 8'h04, 8'h00);
        fork drive(0); drive(1); join
        wait_idle();
        chk("raw_order", gnt_log.size() == 2 && gnt_log[0] == 0, 1);

        // Reset asserted during the ISSUE cycle of a master 1 read.
        push(1, 1'b0, 8'h04, 8'h00);
        drive(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        gnt_log.delete();
        push(0, 1'b1, 8'h05, 8'h55);
        push(1, 1'b1, 8'h06, 8'h66);
        fork drive(0); drive(1); join_none
        @(negedge clk);
        chk("rst_mid_rsp1", bus.rsp1_valid, 0);
        chk("rst_mid_ready", {bus.req1_ready, bus.req0_ready}, 2'b01);
        wait fork;
        wait_idle();
        chk("rst_mid_first_gnt", gnt_log.size() > 0 && gnt_log[0] == 0, 1);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-requester controller for the team's single-port synchronous SRAM (8-bit address/data, cs/we/rd strobes, read data registered on the access edge). Accepts read/write commands from two independent masters over valid/ready, arbitrates round-robin, sequences exactly one SRAM access at a time, and returns a one-cycle response pulse to the originating master. Sits between the masters and the SRAM instance; it is the only driver of the SRAM control pins.

Parameters:
AW, 8, address width (matches SRAM addr)
DW, 8, data width (matches SRAM data_i/data_o)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  master 0 command valid
req0_we  in  1  master 0 op: 1=write, 0=read
req0_addr  in  AW  master 0 address
req0_wdata  in  DW  master 0 write data
req0_ready  out  1  master 0 command accepted this cycle
rsp0_valid  out  1  master 0 completion pulse
rsp0_rdata  out  DW  master 0 read data
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata  same as master 0, for master 1
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write strobe
sram_rd  out  1  SRAM read strobe
sram_addr  out  AW  SRAM address
sram_wdata  out  DW  to SRAM data_i
sram_rdata  in  DW  from SRAM data_o

Behaviour:
- Clock `clk`; reset `rst`, synchronous, active-high.
- Reset: state=IDLE, rr pointer=0 (master 0 preferred), all registered outputs 0 (sram_cs/we/rd, sram_addr, sram_wdata, rsp*_valid, rsp*_rdata).
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any reqN_valid, grant one.
  - Only one valid: grant it.
  - Both valid: grant master != last granted.
  - reqN_ready = (state==IDLE) & grantN. Combinational; never high outside IDLE; never both high.
  - On accept edge: latch op/addr/wdata into sram_we/sram_rd/sram_addr/sram_wdata with sram_cs=1; record owner; update rr pointer; go ISSUE.
  - No valid: stay IDLE.
- ISSUE (exactly 1 cycle): sram_cs=1, exactly one of sram_we/sram_rd =1. SRAM performs access at the edge ending ISSUE.
  - Write: at that edge, drop cs/we, pulse rsp<owner>_valid for the next cycle, go IDLE. rsp_rdata unchanged on writes.
  - Read: drop cs/rd, go CAPTURE.
- CAPTURE (1 cycle): sram_rdata is valid. At the edge ending it, rsp<owner>_rdata <= sram_rdata, rsp<owner>_valid pulses next cycle, go IDLE.
- Latency from accept cycle C0:
  - Write: rsp_valid in C2.
  - Read: rsp_valid + data in C3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- sram_addr/sram_wdata hold their last values outside ISSUE. sram_cs/we/rd are 0 in every state except ISSUE.
- rsp_valid is a single-cycle pulse with no backpressure; at most one rsp*_valid high per cycle.
- Masters hold valid and command stable until ready; the block never drops an accepted command.
- Non-granted valid stays pending; round-robin guarantees service within one other transaction.
- New accept may occur in the same cycle a rsp pulse is high (IDLE).
- Reset mid-operation: state→IDLE, no rsp issued, rr→0.
  - If rst is asserted during ISSUE, the SRAM still sees that access at the edge (SRAM has no reset); the memory side effect of a write is permitted, no response is permitted.

Test Plan:
- Reset held 3 cycles, then both valid low → all outputs 0, req*_ready 0, sram_cs never asserted.
- Master 0 write addr 0x03 data 0x06 accepted at C0 → sram_cs=1, sram_we=1, addr 0x03, wdata 0x06 only in C1; rsp0_valid pulse in C2.
- Master 0 read addr 0x03 accepted at C0 → sram_rd=1 in C1; rsp0_valid=1, rsp0_rdata=0x06 in C3; rsp1_valid stays 0.
- Both masters hold valid continuously, writing addr 0x00..0x03 data 0x10..0x13 → grant order 0,1,0,1 with no starvation; subsequent reads return 0x10..0x13 to the correct master.
- Master 0 writes 0x12 to 0x04, master 1 reads 0x04 in the immediately following IDLE → rsp1_rdata=0x12.
- rst asserted in ISSUE cycle of a master 1 read → no rsp1_valid, IDLE next cycle, then simultaneous valids grant master 0 first.
